// File: rtl/demux_fifo.sv
// Round-robin 1:2 demultiplexer feeding two show-ahead lane FIFOs.
// Words alternate lane 0 / lane 1; each lane has valid/pop, almost-full and reports pop-on-empty.

module demux_fifo_lane #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  valid_o,
  output logic                  full_o,
  output logic                  afull_o,
  output logic                  pop_err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign valid_o   = (count_q != '0);
  assign full_o    = (count_q == FULL_CNT);
  assign afull_o   = (count_q >= AF_CNT);
  assign rdata_o   = valid_o ? mem_q[rd_ptr_q] : '0;
  assign pop_err_o = pop_i & ~valid_o;

  // The top only raises push_i when this lane is not full.
  assign do_push = push_i;
  assign do_pop  = pop_i & valid_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; writes in a reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (reset_L && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

module demux_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  output logic                  lane_sel,
  input  logic                  pop_0,
  input  logic                  pop_1,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic                  valid_out_0,
  output logic                  valid_out_1,
  output logic                  almost_full_0,
  output logic                  almost_full_1,
  output logic                  err
);
  localparam int NUM_LANES = 2;

  logic                                  lane_sel_q, lane_sel_d;
  logic                                  err_q, err_d;
  logic                                  accept;
  logic [NUM_LANES-1:0]                  push, pop, valid, full, afull, pop_err;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  rdata;

  assign pop       = {pop_1, pop_0};
  assign ready_out = ~full[lane_sel_q];
  assign accept    = valid_in & ready_out;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      assign push[g] = accept & (lane_sel_q == g[0]);
      demux_fifo_lane #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)
      ) u_lane (
        .clk      (clk),
        .reset_L  (reset_L),
        .push_i   (push[g]),
        .pop_i    (pop[g]),
        .wdata_i  (data_in),
        .rdata_o  (rdata[g]),
        .valid_o  (valid[g]),
        .full_o   (full[g]),
        .afull_o  (afull[g]),
        .pop_err_o(pop_err[g])
      );
    end
  endgenerate

  always_comb begin
    lane_sel_d = lane_sel_q ^ accept;
    err_d      = err_q | (valid_in & ~ready_out) | (|pop_err);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      lane_sel_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      lane_sel_q <= lane_sel_d;
      err_q      <= err_d;
    end
  end

  assign lane_sel      = lane_sel_q;
  assign err           = err_q;
  assign data_out_0    = rdata[0];
  assign data_out_1    = rdata[1];
  assign valid_out_0   = valid[0];
  assign valid_out_1   = valid[1];
  assign almost_full_0 = afull[0];
  assign almost_full_1 = afull[1];
endmodule

// File: tb/tb_demux_fifo.sv
// Directed plus randomized bench for demux_fifo against a queue-based lane model.
module tb_demux_fifo;
  localparam int DW = 4, DEPTH = 4, AF = 3;

  logic          clk = 1'b0;
  logic          reset_L, valid_in, pop_0, pop_1;
  logic [DW-1:0] data_in;
  logic          ready_out, lane_sel, valid_out_0, valid_out_1;
  logic          almost_full_0, almost_full_1, err;
  logic [DW-1:0] data_out_0, data_out_1;

  always #5 clk = ~clk;

  demux_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out), .lane_sel(lane_sel), .pop_0(pop_0), .pop_1(pop_1),
    .data_out_0(data_out_0), .data_out_1(data_out_1),
    .valid_out_0(valid_out_0), .valid_out_1(valid_out_1),
    .almost_full_0(almost_full_0), .almost_full_1(almost_full_1), .err(err)
  );

  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] q0[$], q1[$];
  bit m_sel = 1'b0, m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Lanes as queues: pops judged on pre-edge occupancy, push accepted when target lane not full.
  task automatic model_step();
    bit rdy;
    if (!reset_L) begin
      q0.delete(); q1.delete(); m_sel = 1'b0; m_err = 1'b0;
    end else begin
      rdy = ((m_sel ? q1.size() : q0.size()) != DEPTH);
      if (pop_0) begin if (q0.size() != 0) void'(q0.pop_front()); else m_err = 1'b1; end
      if (pop_1) begin if (q1.size() != 0) void'(q1.pop_front()); else m_err = 1'b1; end
      if (valid_in) begin
        if (rdy) begin
          if (m_sel) q1.push_back(data_in); else q0.push_back(data_in);
          m_sel = ~m_sel;
        end else m_err = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("valid_out_0", valid_out_0, q0.size() != 0);
    chk("valid_out_1", valid_out_1, q1.size() != 0);
    chk("data_out_0", data_out_0, (q0.size() != 0) ? q0[0] : '0);
    chk("data_out_1", data_out_1, (q1.size() != 0) ? q1[0] : '0);
    chk("almost_full_0", almost_full_0, q0.size() >= AF);
    chk("almost_full_1", almost_full_1, q1.size() >= AF);
    chk("ready_out", ready_out, (m_sel ? q1.size() : q0.size()) != DEPTH);
    chk("lane_sel", lane_sel, m_sel);
    chk("err", err, m_err);
  endtask

  task automatic drive(input bit r, input bit v, input logic [DW-1:0] d, input bit p0, input bit p1);
    reset_L = r; valid_in = v; data_in = d; pop_0 = p0; pop_1 = p1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic push(input logic [DW-1:0] d);
    drive(1, 1, d, 0, 0); cycle();
  endtask

  task automatic do_reset();
    drive(0, 0, '0, 0, 0); cycle();
  endtask

  initial begin
    drive(0, 1, 4'hF, 1, 1);
    // 1: reset with busy inputs
    cycle(); cycle();
    drive(1, 0, '0, 0, 0); cycle();
    chk("rst_valid_out_0", valid_out_0, 0);
    chk("rst_data_out_1", data_out_1, 0);
    chk("rst_ready_out", ready_out, 1);
    chk("rst_err", err, 0);

    // 2: split
    push(4'hA); push(4'h5); push(4'h3); push(4'hC);
    chk("split_d0", data_out_0, 4'hA);
    chk("split_d1", data_out_1, 4'h5);
    chk("split_sel", lane_sel, 0);
    drive(1, 0, '0, 1, 0); cycle();
    chk("split_pop_d0", data_out_0, 4'h3);

    // 3: full and almost-full
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      push(4'(i));
      if (i == 4) chk("af0_before", almost_full_0, 0);
      if (i == 5) chk("af0_after5", almost_full_0, 1);
    end
    chk("full_ready", ready_out, 0);
    chk("full_sel", lane_sel, 0);
    push(4'h9);
    chk("reject_err", err, 1);
    chk("reject_sel", lane_sel, 0);
    chk("reject_d0", data_out_0, 4'h1);

    // 4: pop on empty
    do_reset();
    drive(1, 0, '0, 0, 1); cycle();
    chk("empty_pop_err", err, 1);
    chk("empty_pop_v1", valid_out_1, 0);

    // 5: concurrent push and pop on lane 0
    do_reset();
    push(4'h2); push(4'h1); push(4'h4); push(4'h3);
    drive(1, 1, 4'h6, 1, 0); cycle();
    chk("pp_d0", data_out_0, 4'h4);
    chk("pp_sel", lane_sel, 1);
    chk("pp_err", err, 0);
    drive(1, 0, '0, 1, 0); cycle();
    chk("pp_d0_next", data_out_0, 4'h6);

    // 6: reset mid-operation
    do_reset();
    drive(1, 0, '0, 1, 0); cycle();
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    chk("mid_err_set", err, 1);
    do_reset();
    chk("mid_v0", valid_out_0, 0);
    chk("mid_err", err, 0);
    chk("mid_sel", lane_sel, 0);
    push(4'h7);
    chk("mid_d0", data_out_0, 4'h7);

    // Randomized traffic with phases biased toward filling or draining
    for (int i = 0; i < 600; i++) begin
      int ph;
      ph = (i / 50) % 3;
      drive(($urandom_range(0, 79) != 0),
            (ph == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 4),
            4'($urandom),
            (ph == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6),
            (ph == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/demux_fifo.md
Name: demux_fifo

Overview:
- Downstream neighbour of the 2:1 4-bit mux stage. Consumes its serialized 4-bit stream and splits it back into two lanes.
- Lane assignment is round-robin: words alternate lane 0, lane 1, lane 0, …
- Each lane is buffered in a small show-ahead FIFO with valid/pop handshake, almost-full indication and a sticky error flag.

Parameters:
- DATA_WIDTH, 4, width of every data word.
- DEPTH, 4, entries per lane FIFO; power of 2, at least 2.
- AF_LEVEL, 3, occupancy at or above which almost_full_x asserts; must satisfy 1 <= AF_LEVEL <= DEPTH.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset_L  in  1  synchronous, active-low reset.
- valid_in  in  1  data_in carries a word this cycle.
- data_in  in  DATA_WIDTH  input word (mux data_out).
- ready_out  out  1  block can accept a word this cycle.
- lane_sel  out  1  lane the next accepted word goes to.
- pop_0  in  1  consumer takes the head word of lane 0.
- pop_1  in  1  consumer takes the head word of lane 1.
- data_out_0  out  DATA_WIDTH  head word of lane 0.
- data_out_1  out  DATA_WIDTH  head word of lane 1.
- valid_out_0  out  1  lane 0 non-empty.
- valid_out_1  out  1  lane 1 non-empty.
- almost_full_0  out  1  lane 0 count >= AF_LEVEL.
- almost_full_1  out  1  lane 1 count >= AF_LEVEL.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Clock and reset: one clock, clk. reset_L is synchronous and active-low, sampled only on the posedge of clk.
- Reset (reset_L=0 at posedge):
  - all counts, read/write pointers, lane_sel and err cleared to 0.
  - Memory contents are not reset.
  - Outputs after the reset edge: valid_out_x=0, data_out_x=0, almost_full_x=0, ready_out=1, lane_sel=0, err=0.
  - Reset dominates every other input in the same cycle; pushes and pops in a reset cycle are discarded.
- Per-lane state:
  - mem[DEPTH], wr_ptr and rd_ptr of width log2(DEPTH), wrapping naturally from DEPTH-1 to 0.
  - count of width log2(DEPTH)+1, range 0..DEPTH.
- ready_out = (count of lane lane_sel != DEPTH). It is combinational from registered state only and does not depend on the same-cycle pop.
- Accept = valid_in & ready_out. On accept:
  - mem[lane_sel][wr_ptr] <= data_in; wr_ptr++; lane_sel toggles.
- Reject = valid_in & ~ready_out. The word is dropped, lane_sel does not toggle, and err <= 1.
- Show-ahead output:
  - valid_out_x = (count_x != 0).
  - data_out_x = mem[rd_ptr_x] when valid_out_x=1, else 0.
  - Latency: a word accepted at edge N is visible on data_out_x/valid_out_x right after edge N, i.e. one cycle from data_in to data_out.
- Pop:
  - pop_x & valid_out_x: rd_ptr_x++, count decrements.
  - pop_x & ~valid_out_x: ignored, err <= 1.
- Simultaneous push and pop on the same lane:
  - count non-zero and not full: count unchanged, both pointers advance.
  - count=0: the push succeeds; the pop is on-empty, so it is ignored and err is set.
  - count=DEPTH: the push is rejected (ready_out=0) and the pop proceeds. There is no push-through when full.
- A pop on one lane and a push on the other lane are independent.
- almost_full_x = (count_x >= AF_LEVEL), decoded from registered count.
- err stays 1 until reset.
- No combinational path from data_in or pop_x to any output.

Test Plan:
1. Reset: reset_L=0 for 2 cycles with valid_in=1, data_in=0xF, pop_0=pop_1=1 -> after release: valid_out_0/1=0, data_out_0/1=0x0, ready_out=1, lane_sel=0, err=0.
2. Split: push 0xA, 0x5, 0x3, 0xC on consecutive cycles, no pops -> data_out_0=0xA, data_out_1=0x5, both valid_out=1, lane_sel=0. Then pop_0 for one cycle -> data_out_0=0x3.
3. Full and almost-full:
   - push words 0x1..0x8, no pops -> almost_full_0=1 right after the 5th accept (0x5).
   - after the 8th accept: both lanes count 4, lane_sel=0, ready_out=0.
   - then valid_in=1 with data_in=0x9 -> err=1, lane_sel stays 0, data_out_0 stays 0x1.
4. Pop on empty: after reset, pop_1=1 for one cycle -> err=1, valid_out_1=0, counts unchanged.
5. Concurrent push and pop:
   - setup: lane 0 holds {0x2, 0x4} and lane_sel=0.
   - stimulus: valid_in=1, data_in=0x6 and pop_0=1 in the same cycle.
   - expected: data_out_0=0x4, lane 0 count stays 2, lane_sel=1, err=0.
6. Reset mid-operation:
   - setup: both lanes hold 2 words and err=1.
   - stimulus: reset_L=0 for one cycle.
   - expected: valid_out_0/1=0, data_out_0/1=0, err=0, lane_sel=0.
   - follow-up: push 0x7 -> data_out_0=0x7.
